// File: rtl/sfm_denominator_accumulator.sv
// sfm_denominator_accumulator: lane-parallel softmax denominator accumulation with
// per-beat online-max rescale, serial lane reduction and a held sum handshake.
module sfm_denominator_accumulator #(
    parameter int N_LANES     = 8,
    parameter int IN_WIDTH    = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          clear_regs_i,
    input  logic                          acc_finished_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [N_LANES*IN_WIDTH-1:0]   in_data_i,
    input  logic [N_LANES-1:0]            in_strb_i,
    input  logic [SHIFT_WIDTH-1:0]        rescale_i,
    output logic                          busy_o,
    output logic                          reducing_o,
    output logic                          sum_valid_o,
    input  logic                          sum_ready_i,
    output logic [ACC_WIDTH-1:0]          sum_o,
    output logic                          sat_o
);
    localparam int KW = N_LANES > 1 ? $clog2(N_LANES) : 1;

    typedef enum logic [1:0] {ACC, REDUCE, DONE} state_t;
    typedef logic [ACC_WIDTH:0] wide_t;

    state_t                        state, state_nxt;
    logic                          s1_valid;
    logic [N_LANES*IN_WIDTH-1:0]   s1_data;
    logic [N_LANES-1:0]            s1_strb;
    logic [SHIFT_WIDTH-1:0]        s1_rescale;
    logic [ACC_WIDTH-1:0]          acc [N_LANES];
    logic [ACC_WIDTH-1:0]          acc_nxt [N_LANES];
    logic [N_LANES-1:0]            lane_sat;
    logic [KW-1:0]                 k;
    wide_t                         sum_total;
    logic                          accept, go_reduce;

    assign in_ready_o  = state == ACC;
    assign reducing_o  = state == REDUCE;
    assign sum_valid_o = state == DONE;
    assign busy_o      = s1_valid | in_valid_i;
    assign accept      = in_valid_i & in_ready_o;
    // Only leave ACC once no beat is in flight, so every accepted beat is summed.
    assign go_reduce   = acc_finished_i & ~s1_valid & ~accept;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        logic [ACC_WIDTH-1:0] shifted;
        wide_t                total;
        assign shifted     = int'(s1_rescale) >= ACC_WIDTH ? '0 : acc[l] >> s1_rescale;
        assign total       = wide_t'(shifted) + wide_t'(s1_strb[l] ? s1_data[l*IN_WIDTH +: IN_WIDTH] : '0);
        assign acc_nxt[l]  = total[ACC_WIDTH] ? '1 : total[ACC_WIDTH-1:0];
        assign lane_sat[l] = total[ACC_WIDTH];
    end

    assign sum_total = wide_t'(k == '0 ? '0 : sum_o) + wide_t'(acc[k]);

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (go_reduce) state_nxt = REDUCE;
            REDUCE:  if (k == KW'(N_LANES - 1)) state_nxt = DONE;
            DONE:    if (sum_ready_i) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ACC;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_strb    <= '0;
            s1_rescale <= '0;
            k          <= '0;
            sum_o      <= '0;
            sat_o      <= 1'b0;
            acc        <= '{default: '0};
        end else if (clear_i) begin
            state      <= ACC;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_strb    <= '0;
            s1_rescale <= '0;
            k          <= '0;
            sum_o      <= '0;
            sat_o      <= 1'b0;
            acc        <= '{default: '0};
        end else begin
            state    <= state_nxt;
            s1_valid <= accept;
            k        <= state == REDUCE ? k + 1'b1 : '0;
            if (accept) begin
                s1_data    <= in_data_i;
                s1_strb    <= in_strb_i;
                s1_rescale <= rescale_i;
            end
            if (clear_regs_i) begin
                acc   <= '{default: '0};
                sum_o <= '0;
                sat_o <= 1'b0;
            end else begin
                if (s1_valid) begin
                    acc <= acc_nxt;
                    if (|lane_sat) sat_o <= 1'b1;
                end
                if (state == REDUCE) begin
                    sum_o <= sum_total[ACC_WIDTH] ? '1 : sum_total[ACC_WIDTH-1:0];
                    if (sum_total[ACC_WIDTH]) sat_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sfm_denominator_accumulator.sv
// tb_sfm_denominator_accumulator: directed and random beats against a lane-array model;
// expected sums go to a scoreboard that a monitor drains on each sum handshake.
module tb_sfm_denominator_accumulator;
    localparam int N  = 8;
    localparam int IW = 16;
    localparam int AW = 24;
    localparam int SW = 5;
    localparam longint unsigned MAXV = (64'd1 << AW) - 1;

    logic clk = 0, rst_n = 0, clear = 0, clear_regs = 0, acc_finished = 0;
    logic in_valid = 0, sum_ready = 0;
    logic [N*IW-1:0] in_data = '0;
    logic [N-1:0]    in_strb = '0;
    logic [SW-1:0]   rescale = '0;
    logic            in_ready, busy, reducing, sum_valid, sat;
    logic [AW-1:0]   sum;

    int checks = 0, errors = 0;
    longint unsigned m_acc [N];
    bit m_sat;
    typedef struct {longint unsigned sum; bit sat;} exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    sfm_denominator_accumulator #(.N_LANES(N), .IN_WIDTH(IW), .ACC_WIDTH(AW), .SHIFT_WIDTH(SW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .clear_regs_i(clear_regs),
        .acc_finished_i(acc_finished), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_strb_i(in_strb), .rescale_i(rescale), .busy_o(busy),
        .reducing_o(reducing), .sum_valid_o(sum_valid), .sum_ready_i(sum_ready),
        .sum_o(sum), .sat_o(sat)
    );

    task automatic check(string name, longint unsigned act, longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int l = 0; l < N; l++) m_acc[l] = 0;
        m_sat = 0;
    endtask

    task automatic model_beat(logic [N*IW-1:0] d, logic [N-1:0] s, logic [SW-1:0] rs);
        for (int l = 0; l < N; l++) begin
            longint unsigned v = rs >= AW ? 0 : m_acc[l] >> rs;
            if (s[l]) v += d[l*IW +: IW];
            if (v > MAXV) begin
                v = MAXV;
                m_sat = 1;
            end
            m_acc[l] = v;
        end
    endtask

    task automatic beat(logic [N*IW-1:0] d, logic [N-1:0] s, logic [SW-1:0] rs);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL beat: in_ready stuck at 0 expected 1");
        end
        in_valid = 1; in_data = d; in_strb = s; rescale = rs;
        model_beat(d, s, rs);
        tick();
        in_valid = 0;
    endtask

    task automatic clr_regs();
        clear_regs = 1;
        tick();
        clear_regs = 0;
        model_zero();
        check("clear_regs sat", sat, 0);
    endtask

    task automatic finish_round(string name);
        int n = 0;
        longint unsigned s = 0;
        exp_t e;
        for (int l = 0; l < N; l++) s += m_acc[l];
        if (s > MAXV) begin
            s = MAXV;
            m_sat = 1;
        end
        e.sum = s; e.sat = m_sat;
        sb.push_back(e);
        acc_finished = 1;
        while (!reducing && n < 40) begin tick(); n++; end
        acc_finished = 0;
        if (!reducing) begin
            checks++; errors++;
            $display("FAIL %s start: reducing 0 expected 1", name);
            return;
        end
        n = 0;
        while (reducing && n < 40) begin tick(); n++; end
        check({name, " reduce cycles"}, n, N);
        check({name, " sum_valid"}, sum_valid, 1);
        repeat (3) tick();
        check({name, " sum_valid held"}, sum_valid, 1);
        sum_ready = 1;
        tick();
        sum_ready = 0;
        check({name, " released"}, {sum_valid, in_ready}, 2'b01);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && sum_valid && sum_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected sum: got 0x%0h expected none", sum);
            end else begin
                e = sb.pop_front();
                check("sum_o", sum, e.sum);
                check("sat_o at sum", sat, e.sat);
            end
        end
    end

    initial begin
        bit seen;
        model_zero();
        #12;
        check("reset outputs", {in_ready, busy, reducing, sum_valid, sat, sum}, {1'b1, 4'b0, {AW{1'b0}}});
        tick();
        rst_n = 1;
        tick();
        check("post-reset outputs", {in_ready, busy, reducing, sum_valid, sat}, 5'b10000);

        repeat (4) beat({N{16'h0100}}, 8'hFF, 0);
        finish_round("four beats");

        clr_regs();
        beat({N{16'h0400}}, 8'hFF, 0);
        beat({N{16'h0100}}, 8'hFF, 2);
        finish_round("rescale by 2");

        clr_regs();
        beat({$urandom, $urandom, $urandom, $urandom}, 8'hFF, 0);
        beat({N{16'hFFFF}}, 8'h0F, 31);
        finish_round("strobe and wide shift");

        clr_regs();
        beat({N{16'h0010}}, 8'hFF, 0);
        in_valid = 1; in_data = {N{16'h0020}}; in_strb = 8'hFF; rescale = 1; acc_finished = 1;
        check("busy at accept", busy, 1);
        model_beat(in_data, in_strb, rescale);
        tick();
        in_valid = 0;
        check("busy with beat in flight", {busy, reducing}, 2'b10);
        finish_round("finish with beat");

        clr_regs();
        in_valid = 1; in_data = {N{16'hFFFF}}; in_strb = 8'hFF; rescale = 0;
        for (int i = 0; i < 256; i++) begin
            model_beat(in_data, in_strb, rescale);
            tick();
        end
        in_data = {N{16'h00FE}};
        model_beat(in_data, in_strb, rescale);
        tick();
        in_valid = 0;
        tick();
        check("sat below max", sat, 0);
        beat({N{16'h0010}}, 8'hFF, 0);
        tick();
        check("sat after clamp", sat, 1);
        finish_round("saturated");
        clr_regs();
        finish_round("after clear_regs");

        clr_regs();
        beat({N{16'h0100}}, 8'hFF, 0);
        acc_finished = 1;
        for (int i = 0; i < 40 && !reducing; i++) tick();
        tick();
        tick();
        clear = 1; acc_finished = 0;
        tick();
        clear = 0;
        model_zero();
        check("clear mid reduce", {reducing, in_ready, sum_valid, sum}, {3'b010, {AW{1'b0}}});
        seen = 0;
        repeat (12) begin tick(); seen |= sum_valid; end
        check("no sum after clear", seen, 0);

        for (int r = 0; r < 4; r++) begin
            int nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                logic [N*IW-1:0] d = {$urandom, $urandom, $urandom, $urandom};
                logic [N-1:0] s = N'($urandom);
                logic [SW-1:0] rs = $urandom_range(0, 7) == 0 ? SW'($urandom_range(20, 31)) : SW'($urandom_range(0, 3));
                beat(d, s, rs);
                repeat ($urandom_range(0, 2)) tick();
            end
            finish_round("random round");
        end

        repeat (3) tick();
        check("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
